ex_muldiv: RTL and testbench

EX_MULDIV -- requirements
Module: ex_muldiv

---
 rtl/ex_muldiv.sv | 164 ++++++++++++++++
 tb/tb_ex_muldiv.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Performs one shift-add or restoring-divide step per cycle, 32 steps per op.
module ex_muldiv #(
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic                qneg_q, qneg_d;
  logic                rneg_q, rneg_d;
  logic                spec_q, spec_d;
  logic [XLEN-1:0]     spec_val_q, spec_val_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [2*XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]     mplier_q, mplier_d;
  logic [XLEN-1:0]     result_q, result_d;

  // Operand signedness and magnitudes at the accept edge
  logic            a_signed, b_signed, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, special_val;

  assign a_signed    = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign b_signed    = funct3[2] ? ~funct3[0] : ~funct3[1];
  assign a_neg       = a_signed & rs1_val[XLEN-1];
  assign b_neg       = b_signed & rs2_val[XLEN-1];
  assign a_mag       = a_neg ? -rs1_val : rs1_val;
  assign b_mag       = b_neg ? -rs2_val : rs2_val;
  assign div_zero    = (rs2_val == '0);
  assign div_ovf     = ~funct3[0] & (rs1_val == 32'h8000_0000) & (rs2_val == '1);
  assign special_val = div_zero ? (funct3[1] ? rs1_val : '1)
                                : (funct3[1] ? '0 : 32'h8000_0000);

  // Per-cycle datapath steps; acc holds {remainder, dividend/quotient} while dividing
  logic [2*XLEN-1:0] mul_sum, prod, div_acc;
  logic [XLEN:0]     div_trial;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem, quo, rem;

  assign mul_sum   = acc_q + (mplier_q[0] ? opb_q : '0);
  assign prod      = qneg_q ? -mul_sum : mul_sum;
  assign div_trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_ge    = div_trial >= {1'b0, opb_q[XLEN-1:0]};
  assign div_rem   = div_ge ? (div_trial[XLEN-1:0] - opb_q[XLEN-1:0]) : div_trial[XLEN-1:0];
  assign div_acc   = {div_rem, acc_q[XLEN-2:0], div_ge};
  assign quo       = qneg_q ? -div_acc[XLEN-1:0] : div_acc[XLEN-1:0];
  assign rem       = rneg_q ? -div_acc[2*XLEN-1:XLEN] : div_acc[2*XLEN-1:XLEN];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    acc_d      = acc_q;
    opb_d      = opb_q;
    mplier_d   = mplier_q;
    result_d   = result_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_d = IDLE;
          if (start) begin
            op_d   = funct3[1:0];
            qneg_d = a_neg ^ b_neg;
            rneg_d = a_neg;
            cnt_d  = '0;
            if (funct3[2]) begin
              if (EARLY_OUT && (div_zero || div_ovf)) begin
                result_d = special_val;
                state_d  = DONE;
              end else begin
                acc_d      = {{XLEN{1'b0}}, a_mag};
                opb_d      = {{XLEN{1'b0}}, b_mag};
                spec_d     = div_zero | div_ovf;
                spec_val_d = special_val;
                state_d    = DIV;
              end
            end else begin
              acc_d    = '0;
              opb_d    = {{XLEN{1'b0}}, a_mag};
              mplier_d = b_mag;
              state_d  = MUL;
            end
          end
        end
        MUL: begin
          acc_d    = mul_sum;
          opb_d    = opb_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            result_d = (op_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
            state_d  = DONE;
          end
        end
        DIV: begin
          acc_d = div_acc;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            result_d = spec_q ? spec_val_q : (op_q[1] ? rem : quo);
            state_d  = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      qneg_q     <= 1'b0;
      rneg_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      acc_q      <= '0;
      opb_q      <= '0;
      mplier_q   <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      qneg_q     <= qneg_d;
      rneg_q     <= rneg_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      acc_q      <= acc_d;
      opb_q      <= opb_d;
      mplier_q   <= mplier_d;
      result_q   <= result_d;
    end
  end

  assign busy   = (state_q == MUL) || (state_q == DIV);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed corner ops plus randomized
// traffic compared each cycle against an arithmetic reference model.
module tb_ex_muldiv;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_vec = 0;
  int n_err = 0;

  ex_muldiv #(.EARLY_OUT(1'b1)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .funct3  (funct3),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result computed with plain 64-bit arithmetic
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb, sub;
    logic [63:0]        ua, ub, p;
    logic [31:0]        r;
    logic               ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    sub = $signed(ub);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sa * sb;  r = p[31:0];  end
      3'd1: begin p = sa * sb;  r = p[63:32]; end
      3'd2: begin p = sa * sub; r = p[63:32]; end
      3'd3: begin p = ua * ub;  r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_early(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Behavioural model: busy-cycle countdown and pending result
  int          m_cnt;
  logic        m_done;
  logic [31:0] m_res;
  logic [31:0] m_pend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_res  <= 32'h0;
    end else if (flush) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_done <= 1'b1;
        m_res  <= m_pend;
      end
    end else begin
      m_done <= 1'b0;
      if (start) begin
        if (is_early(funct3, rs1_val, rs2_val)) begin
          m_done <= 1'b1;
          m_res  <= ref_res(funct3, rs1_val, rs2_val);
        end else begin
          m_cnt  <= 32;
          m_pend <= ref_res(funct3, rs1_val, rs2_val);
        end
      end
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc busy", 32'(busy), 32'(m_cnt != 0));
      chk("cyc done", 32'(done), 32'(m_done));
      chk("cyc result", result, m_res);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, wait (bounded) for done, check latency/result/busy count
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input string name);
    int lat;
    int nb;
    start   = 1'b1;
    funct3  = f;
    rs1_val = a;
    rs2_val = b;
    step();
    start   = 1'b0;
    funct3  = 3'($urandom);
    rs1_val = $urandom;
    rs2_val = $urandom;
    lat = 1;
    nb  = busy ? 1 : 0;
    while (!done && lat < 40) begin
      step();
      lat++;
      if (busy) nb++;
    end
    chk({name, " latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " result"}, result, exp);
    if (exp_lat == 33) chk({name, " busy cycles"}, 32'(nb), 32'd32);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dones;
    rst = 1'b0; start = 1'b0; flush = 1'b0;
    funct3 = 3'd0; rs1_val = 32'h0; rs2_val = 32'h0;
    #2 rst = 1'b1;
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset result", result, 32'h0);
    chk_en = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "MUL 7x-3");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "MULH");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "MULHU");
    step();
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "MULHSU");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "DIV -7/2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "REM -7/2");
    step();
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 33, "DIVU 100/7");
    run_op(3'd7, 32'd100, 32'd7, 32'd2, 33, "REMU 100/7");
    run_op(3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, 1, "DIVU by 0");
    run_op(3'd7, 32'd100, 32'd0, 32'd100, 1, "REMU by 0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "DIV overflow");
    run_op(3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1, "DIV -7/0");
    step();

    // Flush on the 10th DIV cycle; result must keep the last value (0xFFFFFFFF)
    start = 1'b1; funct3 = 3'd4; rs1_val = 32'd1000; rs2_val = 32'd3;
    step();
    start = 1'b0;
    repeat (9) step();
    chk("flush busy before", 32'(busy), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush busy", 32'(busy), 32'd0);
    chk("flush done", 32'(done), 32'd0);
    chk("flush result", result, 32'hFFFF_FFFF);
    dones = 0;
    repeat (40) begin
      step();
      if (done) dones++;
    end
    chk("flush no done", 32'(dones), 32'd0);

    // Flush and start together in IDLE: the op is dropped
    start = 1'b1; flush = 1'b1; funct3 = 3'd0; rs1_val = 32'd3; rs2_val = 32'd5;
    step();
    start = 1'b0; flush = 1'b0;
    chk("flush+start busy", 32'(busy), 32'd0);
    chk("flush+start done", 32'(done), 32'd0);

    // Asynchronous reset mid-MUL
    start = 1'b1; funct3 = 3'd0; rs1_val = 32'd3; rs2_val = 32'd5;
    step();
    start = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    #1;
    chk("async rst busy", 32'(busy), 32'd0);
    chk("async rst done", 32'(done), 32'd0);
    chk("async rst result", result, 32'h0);
    step();
    rst = 1'b0;
    step();
    run_op(3'd0, 32'd3, 32'd5, 32'd15, 33, "MUL after rst");

    // Randomized traffic, checked every cycle against the model
    for (int i = 0; i < 3000; i++) begin
      start   = ($urandom_range(0, 3) == 0);
      flush   = ($urandom_range(0, 63) == 0);
      funct3  = 3'($urandom);
      rs1_val = pick();
      rs2_val = pick();
      step();
    end
    start = 1'b0;
    flush = 1'b0;
    repeat (40) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
